// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types
// for the RISC-V core pipeline stages.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic {
    RUN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with
// next-PC select and +4 incrementer.
module fetch_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic        hold,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] pc_next;

  assign pc_plus4 = pc + 32'd4;

  // redirect beats hold; targets forced word-aligned
  always_comb begin
    pc_next = pc_plus4;
    if (redirect)
      pc_next = target & 32'hFFFF_FFFC;
    else if (hold)
      pc_next = pc;
  end

  // PC state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, IF/ID register,
// run/halt FSM and fetch counter.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEF,
  parameter bit          HALT_ON_EBREAK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        halted,
  output logic [31:0] fetch_count
);

  fetch_state_t state, state_next;
  if_id_t       if_id;
  logic [31:0]  pc, pc_plus4;
  logic         kill, load, halt_entry;
  logic         pc_hold;

  assign kill       = flush_d | pc_src_e;
  assign load       = !kill && !stall_d && (state == RUN);
  assign halt_entry = HALT_ON_EBREAK && load &&
                      (imem_rd == EBREAK_INSTR);
  // PC parks on the EBREAK address from the entry cycle on
  assign pc_hold    = stall_f | (state == HALT) | halt_entry;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .redirect(pc_src_e),
    .target  (pc_target_e),
    .hold    (pc_hold),
    .pc      (pc),
    .pc_plus4(pc_plus4)
  );

  // run/halt state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= RUN;
    else
      state <= state_next;
  end

  // next state: EBREAK halts, redirect resumes
  always_comb begin
    state_next = state;
    case (state)
      RUN:  if (halt_entry) state_next = HALT;
      HALT: if (pc_src_e)   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // IF/ID register: kill > stall > halt > load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      if_id <= '0;
    else if (kill)
      if_id <= '0;
    else if (!stall_d) begin
      if (state == HALT)
        if_id <= '0;
      else
        if_id <= '{imem_rd, pc, pc_plus4, 1'b1};
    end
  end

  // count valid loads into IF/ID
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      fetch_count <= '0;
    else if (load)
      fetch_count <= fetch_count + 32'd1;
  end

  assign imem_addr  = pc;
  assign instr_d    = if_id.instr;
  assign pc_d       = if_id.pc;
  assign pc_plus4_d = if_id.pc_plus4;
  assign valid_d    = if_id.valid;
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table plus
// randomized run against a fetch model.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sf, sd, fl, src;
  logic [31:0] tgt;

  logic [31:0] addr, rd, instr, pcd, pc4d, cnt;
  logic        vld, hlt;
  logic [31:0] addr2, rd2, instr2, pcd2, pc4d2, cnt2;
  logic        vld2, hlt2;

  logic [31:0] mem [64];

  int total = 0;
  int bad   = 0;

  assign rd  = mem[addr[7:2]];
  assign rd2 = mem[addr2[7:2]];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_addr(addr), .imem_rd(rd),
    .stall_f(sf), .stall_d(sd),
    .flush_d(fl), .pc_src_e(src),
    .pc_target_e(tgt),
    .instr_d(instr), .pc_d(pcd),
    .pc_plus4_d(pc4d), .valid_d(vld),
    .halted(hlt), .fetch_count(cnt)
  );

  fetch_stage #(
    .RESET_PC(32'hFFFF_FFF8),
    .HALT_ON_EBREAK(1'b0)
  ) dut2 (
    .clk(clk), .rst(rst),
    .imem_addr(addr2), .imem_rd(rd2),
    .stall_f(sf), .stall_d(sd),
    .flush_d(fl), .pc_src_e(src),
    .pc_target_e(tgt),
    .instr_d(instr2), .pc_d(pcd2),
    .pc_plus4_d(pc4d2), .valid_d(vld2),
    .halted(hlt2), .fetch_count(cnt2)
  );

  typedef struct {
    logic        sf, sd, fl, src;
    logic [31:0] tgt;
    logic [31:0] e_addr, e_instr, e_pcd;
    logic        e_vld, e_hlt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vt [19];

  // reference model state
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_cnt;
  logic        m_vld, m_hlt;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sf = 1'b0; sd = 1'b0; fl = 1'b0;
    src = 1'b0; tgt = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".addr"}, addr, 32'h0);
    chk({tag, ".instr"}, instr, 32'h0);
    chk({tag, ".pcd"}, pcd, 32'h0);
    chk({tag, ".pc4d"}, pc4d, 32'h0);
    chk({tag, ".vld"}, {31'b0, vld}, 32'h0);
    chk({tag, ".hlt"}, {31'b0, hlt}, 32'h0);
    chk({tag, ".cnt"}, cnt, 32'h0);
    chk({tag, ".addr2"}, addr2, 32'hFFFF_FFF8);
    chk({tag, ".vld2"}, {31'b0, vld2}, 32'h0);
    chk({tag, ".hlt2"}, {31'b0, hlt2}, 32'h0);
    chk({tag, ".cnt2"}, cnt2, 32'h0);
  endtask

  task automatic m_reset();
    m_pc = 32'h0; m_instr = '0; m_pcd = '0;
    m_pc4 = '0; m_vld = 1'b0; m_hlt = 1'b0;
    m_cnt = '0;
  endtask

  // one clock of the fetch rules, from the current inputs
  task automatic m_step();
    logic [31:0] w, np;
    logic        accept, to_halt;
    w       = mem[m_pc[7:2]];
    accept  = !fl && !src && !sd && !m_hlt;
    to_halt = accept && (w == EBREAK_INSTR);
    if (src)
      np = {tgt[31:2], 2'b00};
    else if (m_hlt || to_halt || sf)
      np = m_pc;
    else
      np = m_pc + 32'd4;
    if (fl || src || (!sd && m_hlt)) begin
      m_instr = '0; m_pcd = '0;
      m_pc4 = '0; m_vld = 1'b0;
    end else if (!sd) begin
      m_instr = w; m_pcd = m_pc;
      m_pc4 = m_pc + 32'd4; m_vld = 1'b1;
    end
    if (accept) m_cnt = m_cnt + 32'd1;
    m_hlt = m_hlt ? !src : to_halt;
    m_pc  = np;
  endtask

  localparam logic [31:0] EB = EBREAK_INSTR;
  localparam logic [31:0] W0 = 32'h1000_0000;

  initial begin
    for (int k = 0; k < 64; k++)
      mem[k] = W0 + k;
    mem[0] = 32'h0062_E233;
    mem[1] = 32'h00B6_2423;
    mem[3] = EB;

    vt[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h0, 32'h04,32'h0062E233,32'h00,1'b1,1'b0,32'd1};
    vt[1]  = '{1'b0,1'b0,1'b0,1'b0,32'h0, 32'h08,32'h00B62423,32'h04,1'b1,1'b0,32'd2};
    vt[2]  = '{1'b1,1'b1,1'b0,1'b0,32'h0, 32'h08,32'h00B62423,32'h04,1'b1,1'b0,32'd2};
    vt[3]  = vt[2];
    vt[4]  = vt[2];
    vt[5]  = '{1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0C,W0+2,32'h08,1'b1,1'b0,32'd3};
    vt[6]  = '{1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0C,EB,32'h0C,1'b1,1'b1,32'd4};
    vt[7]  = '{1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0C,32'h0,32'h00,1'b0,1'b1,32'd4};
    vt[8]  = vt[7];
    vt[9]  = '{1'b0,1'b0,1'b0,1'b1,32'h22,32'h20,32'h0,32'h00,1'b0,1'b0,32'd4};
    vt[10] = '{1'b0,1'b0,1'b0,1'b0,32'h0, 32'h24,W0+8,32'h20,1'b1,1'b0,32'd5};
    vt[11] = '{1'b0,1'b0,1'b0,1'b0,32'h0, 32'h28,W0+9,32'h24,1'b1,1'b0,32'd6};
    vt[12] = '{1'b0,1'b0,1'b0,1'b1,32'h43,32'h40,32'h0,32'h00,1'b0,1'b0,32'd6};
    vt[13] = '{1'b0,1'b0,1'b0,1'b0,32'h0, 32'h44,W0+16,32'h40,1'b1,1'b0,32'd7};
    vt[14] = '{1'b1,1'b1,1'b0,1'b1,32'h11,32'h10,32'h0,32'h00,1'b0,1'b0,32'd7};
    vt[15] = '{1'b0,1'b0,1'b0,1'b0,32'h0, 32'h14,W0+4,32'h10,1'b1,1'b0,32'd8};
    vt[16] = '{1'b0,1'b0,1'b1,1'b0,32'h0, 32'h18,32'h0,32'h00,1'b0,1'b0,32'd8};
    vt[17] = '{1'b1,1'b0,1'b0,1'b0,32'h0, 32'h18,W0+6,32'h18,1'b1,1'b0,32'd9};
    vt[18] = '{1'b0,1'b0,1'b0,1'b0,32'h0, 32'h1C,W0+6,32'h18,1'b1,1'b0,32'd10};

    idle();
    tick();
    tick();
    chk_reset_vals("rst");

    // directed table
    rst = 1'b1;
    for (int i = 0; i < 19; i++) begin
      sf = vt[i].sf; sd = vt[i].sd;
      fl = vt[i].fl; src = vt[i].src;
      tgt = vt[i].tgt;
      tick();
      chk($sformatf("v%0d.addr", i), addr, vt[i].e_addr);
      chk($sformatf("v%0d.instr", i), instr, vt[i].e_instr);
      chk($sformatf("v%0d.pcd", i), pcd, vt[i].e_pcd);
      chk($sformatf("v%0d.pc4d", i), pc4d,
          vt[i].e_vld ? vt[i].e_pcd + 32'd4 : 32'h0);
      chk($sformatf("v%0d.vld", i), {31'b0, vld},
          {31'b0, vt[i].e_vld});
      chk($sformatf("v%0d.hlt", i), {31'b0, hlt},
          {31'b0, vt[i].e_hlt});
      chk($sformatf("v%0d.cnt", i), cnt, vt[i].e_cnt);
    end

    // asynchronous reset mid-run, seen before any edge
    idle();
    rst = 1'b0;
    #1;
    chk_reset_vals("arst");
    tick();
    rst = 1'b1;

    // first fetch after release, plus PC wrap on dut2
    tick();
    chk("rel.addr", addr, 32'h4);
    chk("rel.instr", instr, 32'h0062_E233);
    chk("wrap.addr1", addr2, 32'hFFFF_FFFC);
    chk("wrap.instr1", instr2, W0 + 62);
    chk("wrap.pcd1", pcd2, 32'hFFFF_FFF8);
    tick();
    chk("wrap.addr2", addr2, 32'h0);
    chk("wrap.pcd2", pcd2, 32'hFFFF_FFFC);
    chk("wrap.pc4d2", pc4d2, 32'h0);
    chk("wrap.vld2", {31'b0, vld2}, 32'h1);
    tick();
    chk("wrap.addr3", addr2, 32'h4);
    chk("wrap.instr3", instr2, 32'h0062_E233);
    chk("wrap.cnt2", cnt2, 32'd3);

    // randomized run against the model
    rst = 1'b0;
    for (int k = 0; k < 64; k++)
      mem[k] = ($urandom_range(0, 7) == 0) ? EB
             : ($urandom | 32'h0000_0100);
    tick();
    rst = 1'b1;
    m_reset();
    for (int c = 0; c < 400; c++) begin
      sf  = ($urandom_range(0, 4) == 0);
      sd  = ($urandom_range(0, 4) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      src = ($urandom_range(0, m_hlt ? 2 : 7) == 0);
      tgt = $urandom;
      m_step();
      tick();
      chk("rnd.addr", addr, m_pc);
      chk("rnd.instr", instr, m_instr);
      chk("rnd.pcd", pcd, m_pcd);
      chk("rnd.pc4d", pc4d, m_pc4);
      chk("rnd.vld", {31'b0, vld}, {31'b0, m_vld});
      chk("rnd.hlt", {31'b0, hlt}, {31'b0, m_hlt});
      chk("rnd.cnt", cnt, m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
